// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI front end: target IDs and the frame state enum.
package mcu_spi_pkg;

  localparam int unsigned NUM_TGT = 4;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StPayload
  } state_e;

endpackage

// File: rtl/mcu_spi_sync.sv
// 2-FF synchroniser plus a third stage for edge detection; rise/fall are registered pulses.
// All stages reset low so a mid-frame reset with SS held low never fakes an SS falling edge.
module mcu_spi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= async_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
      fall_q <= ~s2_q & s3_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 slave front end: routes payload bytes to one of four targets by a leading ID byte.
// Optional idle-SCK frame timeout is enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi
  import mcu_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] tgt_strobe,
  output logic       tgt_start,
  output logic [7:0] tgt_data,
  input  logic [7:0] sys_din,
  input  logic [7:0] hid_din,
  input  logic [7:0] osd_din,
  input  logic [7:0] sdc_din
);

  logic ss_rise, ss_fall, sck_rise, sck_fall;
  logic mosi_q1, mosi_s;

  mcu_spi_sync u_sync_ss (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_ss_n),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  mcu_spi_sync u_sync_sck (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_sck),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_q1 <= 1'b0;
      mosi_s  <= 1'b0;
    end else begin
      mosi_q1 <= spi_mosi;
      mosi_s  <= mosi_q1;
    end
  end

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, rx_next;
  logic [7:0] tx_q, tx_d;
  logic [7:0] target_q, target_d;
  logic       target_vld_q, target_vld_d;
  logic       first_q, first_d;
  logic [1:0] reload_q, reload_d;
  logic [3:0] strobe_q, strobe_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       tgt_ok, byte_done, abort, timeout;
  logic [7:0] din_sel;

`ifdef MCU_SPI_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= 32'd0;
    end else if (state_q == StIdle || sck_rise || sck_fall || ss_fall) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end

  assign timeout = (state_q != StIdle) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  assign tgt_ok    = target_vld_q && (target_q < 8'(NUM_TGT));
  assign rx_next   = {rx_q[6:0], mosi_s};
  assign byte_done = (state_q != StIdle) && sck_rise && (bit_cnt_q == 3'd7);
  assign abort     = ss_rise | timeout;

  always_comb begin
    din_sel = 8'h00;
    if (tgt_ok) begin
      case (target_q)
        TGT_SYS: din_sel = sys_din;
        TGT_HID: din_sel = hid_din;
        TGT_OSD: din_sel = osd_din;
        TGT_SDC: din_sel = sdc_din;
        default: din_sel = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    target_d     = target_q;
    target_vld_d = target_vld_q;
    first_d      = first_q;
    reload_d     = {reload_q[0], 1'b0};
    strobe_d     = 4'b0000;
    start_d      = 1'b0;
    data_d       = data_q;

    if (abort) begin
      state_d      = StIdle;
      bit_cnt_d    = 3'd0;
      tx_d         = 8'h00;
      target_vld_d = 1'b0;
      first_d      = 1'b0;
      reload_d     = 2'b00;
    end else if (ss_fall) begin
      state_d   = StSelect;
      bit_cnt_d = 3'd0;
      rx_d      = 8'h00;
      tx_d      = 8'h00;
      first_d   = 1'b0;
      reload_d  = 2'b00;
    end else if (state_q != StIdle) begin
      if (sck_rise) begin
        rx_d      = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        reload_d[0] = 1'b1;
        if (state_q == StSelect) begin
          target_d     = rx_next;
          target_vld_d = 1'b1;
          first_d      = 1'b1;
          state_d      = StPayload;
        end else if (tgt_ok) begin
          data_d                = rx_next;
          strobe_d[target_q[1:0]] = 1'b1;
          start_d               = first_q;
          first_d               = 1'b0;
        end
      end
      // The fall that closes a byte must not shift, or it would eat the freshly reloaded MSB.
      if (sck_fall && bit_cnt_q != 3'd0) begin
        tx_d = {tx_q[6:0], 1'b0};
      end
      if (reload_q[1]) begin
        tx_d = din_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      target_q     <= 8'h00;
      target_vld_q <= 1'b0;
      first_q      <= 1'b0;
      reload_q     <= 2'b00;
      strobe_q     <= 4'b0000;
      start_q      <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      target_q     <= target_d;
      target_vld_q <= target_vld_d;
      first_q      <= first_d;
      reload_q     <= reload_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      data_q       <= data_d;
    end
  end

  assign spi_miso   = tx_q[7];
  assign tgt_strobe = strobe_q;
  assign tgt_start  = start_q;
  assign tgt_data   = data_q;

endmodule

// File: doc/mcu_spi.md
# mcu_spi

Serial front end between the companion MCU and the FPGA-side control targets. Receives SPI mode-0 frames on oversampled MCU pins in the `clk` domain, assembles bytes, and routes them by a leading target-ID byte to one of four targets (system control, HID, OSD, SD card). Presents each target with a byte/strobe/start triple. Shifts the selected target's response byte back to the MCU.

## Interface
- `TIMEOUT_CYCLES`, default 32'd1_000_000: idle-SCK cycles with SS low before the frame is aborted (only with `MCU_SPI_TIMEOUT_EN`).
- `clk`  in  1  system clock; all logic in this domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_ss_n`  in  1  MCU chip select, asynchronous, active low.
- `spi_sck`  in  1  MCU serial clock, asynchronous, mode 0.
- `spi_mosi`  in  1  MCU data out, asynchronous.
- `spi_miso`  out  1  data to MCU, MSB first.
- `tgt_strobe`  out  4  one-hot, one-cycle pulse: payload byte valid for target n.
- `tgt_start`  out  1  qualifies `tgt_strobe`: first payload byte of the frame.
- `tgt_data`  out  8  received payload byte; held until the next strobe.
- `sys_din`, `hid_din`, `osd_din`, `sdc_din`  in  8 each  response bytes from targets 0..3.

## Operation
- Synchronise `spi_ss_n`, `spi_sck`, `spi_mosi` with 2-FF chains. A third registered `spi_sck` copy drives rise/fall detection.
- States: IDLE (SS high), SELECT (receiving the target-ID byte), PAYLOAD.
- SS falling edge: clear `bit_cnt` (3 bit), clear the RX shift register, load TX with 8'h00, enter SELECT.
- SCK rise: `rx <= {rx[6:0], mosi_s}`, `bit_cnt++`. When the rise completes bit 7 (`bit_cnt` wraps 7->0), a byte is complete:
  - In SELECT: latch `target <= rx_next[7:0]`, set `first <= 1`, enter PAYLOAD. No strobe.
  - In PAYLOAD with target 0..3: drive `tgt_data <= rx_next`, pulse `tgt_strobe[target]` and `tgt_start <= first`, then clear `first`.
  - In PAYLOAD with target >= 4: drop the byte. No strobe.
- SCK fall: `tx <= {tx[6:0], 1'b0}`. `spi_miso` = `tx[7]`.
- TX reload: 2 cycles after each completed byte, `tx <= din` of the selected target, or 8'h00 for invalid or unlatched targets. The target registers its reply one cycle after the strobe, so the MCU reads reply n during payload byte n+1.
- SS rising edge in any state: return to IDLE. Any partial byte is discarded with no strobe. `target` is invalidated. `tx` is cleared.
- Simultaneous SS rise and byte completion in the same cycle: SS wins and no strobe is issued.
- Async reset mid-frame: everything returns to reset values. The rest of the frame is ignored until the next SS falling edge.
- Reset values: `spi_miso` 0, `tgt_strobe` 4'b0, `tgt_start` 0, `tgt_data` 8'h00, state IDLE, `target` invalid.

## Timing
- SCK must satisfy f_sck <= f_clk/8, with high and low phases of at least 4 clk each.
- Input-to-detect latency: 3 clk from pin edge to internal edge event.
- Byte completion (8th SCK rise at pin) to `tgt_strobe`: 4 clk.
- `tgt_strobe` to TX reload: 2 clk. This must land before the next byte's first SCK rise, which the SCK constraint guarantees.
- Minimum SS-high time between frames: 4 clk.
- `spi_miso` changes at most 1 clk after the detected SCK fall. It is registered.

## Configuration
- `MCU_SPI_TIMEOUT_EN` defined:
  - A 32-bit counter runs while SS is low and resets on every SCK edge.
  - Reaching `TIMEOUT_CYCLES` forces the SS-rise abort behaviour.
  - The block stays in IDLE until SS is seen high, then low again.
- `MCU_SPI_TIMEOUT_EN` undefined: no counter. A frame only ends on SS rise.

## Structure
- Shared package `mcu_spi_pkg`: target IDs `TGT_SYS=0`, `TGT_HID=1`, `TGT_OSD=2`, `TGT_SDC=3`, `NUM_TGT=4`, and the state enum.
- Sub-module `mcu_spi_sync`: 2-FF synchroniser plus edge detector, instantiated for SS and SCK. MOSI uses the plain 2-FF path.

## Test plan
- Frame bytes 00,00,FF,FF,FF with `sys_din` following sysctrl CMD0 (5C,42,00) -> `tgt_strobe`=0001 three... four times; `tgt_start` only on the first; MCU reads 00,00,00,5C,42.
- Frame 02,A5 -> one strobe on bit 2, `tgt_data`=A5, `tgt_start`=1; no other target strobes.
- Frame 07,11,22 -> no strobes; MISO returns all zeros.
- SS rises after 5 bits of a payload byte -> no strobe. The next frame 01,3C delivers 3C to HID with `tgt_start`=1.
- `reset_n` pulsed low mid-payload -> all outputs at reset values immediately. The remaining bits produce no strobe until a new SS falling edge.
- With `MCU_SPI_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: SS held low and SCK stopped for 100 clk after 3 bits -> abort, no strobe. Further SCK pulses are ignored until SS toggles.
